video_timing_ctrl: RTL and testbench

Raster timing and pattern-mode controller that sequences the colour generator. It owns the horizontal and vertical counters and drives `col_addr`, `row_addr`, `ready` (active video) and the sync outputs. It also selects which pattern `mode` the generator renders, holding the mode stable for a whole frame. Mode is set manually or auto-advanced every `FRAMES_PER_MODE` frames, and software reconfigures it through a valid/ready handshake.

---
 rtl/video_timing_pkg.sv | 28 ++
 rtl/timing_axis_counter.sv | 28 ++
 rtl/video_timing_ctrl.sv | 154 +++++++++++++++
 tb/tb_video_timing_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types and raster arithmetic for the video timing controller.
// Axis totals and sync-window bounds are derived from the porch/sync widths.
package video_timing_pkg;

    localparam int CNT_W  = 11;
    localparam int FCNT_W = 16;

    typedef logic [2:0] mode_t;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_state_t;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Sync is asserted for sync_start <= cnt < sync_stop.
    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_stop(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// Wrapping raster axis counter; 'wrap' flags the increment that returns to zero.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int TOTAL = 800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    assign wrap = inc && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator plus per-frame pattern-mode sequencer.
// Mode changes (manual, auto-advance or software request) take effect only at pixel (0,0).
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE        = 640,
    parameter int   H_FP            = 16,
    parameter int   H_SYNC          = 96,
    parameter int   H_BP            = 48,
    parameter int   V_ACTIVE        = 480,
    parameter int   V_FP            = 10,
    parameter int   V_SYNC          = 2,
    parameter int   V_BP            = 33,
    parameter logic HSYNC_POL       = 1'b0,
    parameter logic VSYNC_POL       = 1'b0,
    parameter int   FRAMES_PER_MODE = 60,
    parameter int   NUM_MODES       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        cfg_valid,
    input  logic [2:0]  cfg_mode,
    input  logic        cfg_auto,
    output logic        cfg_ready,
    output logic [10:0] col_addr,
    output logic [10:0] row_addr,
    output logic        ready,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  mode,
    output logic        frame_start
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START  = CNT_W'(sync_start(H_ACTIVE, H_FP));
    localparam logic [CNT_W-1:0] HS_STOP   = CNT_W'(sync_stop(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CNT_W-1:0] VS_START  = CNT_W'(sync_start(V_ACTIVE, V_FP));
    localparam logic [CNT_W-1:0] VS_STOP   = CNT_W'(sync_stop(V_ACTIVE, V_FP, V_SYNC));

    localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'(FRAMES_PER_MODE - 1);
    localparam mode_t             MODE_LAST  = mode_t'(NUM_MODES - 1);
    localparam logic [3:0]        MODE_LIMIT = 4'(NUM_MODES);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             at_origin;
    logic             frame_boundary;

    mode_state_t       state, state_nxt;
    mode_t             mode_nxt;
    logic [FCNT_W-1:0] frame_cnt, frame_cnt_nxt;
    logic              pend, pend_nxt;
    mode_t             pend_mode, pend_mode_nxt;
    logic              pend_auto, pend_auto_nxt;

    timing_axis_counter #(.TOTAL(H_TOTAL)) u_h_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (en),
        .cnt  (h_cnt),
        .wrap (h_wrap)
    );

    timing_axis_counter #(.TOTAL(V_TOTAL)) u_v_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (en && h_wrap),
        .cnt  (v_cnt),
        .wrap (v_wrap)
    );

    // at_origin tracks counters sitting at (0,0) without a second wide compare.
    assign frame_boundary = en && at_origin;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_addr    <= '0;
            row_addr    <= '0;
            ready       <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            frame_start <= 1'b0;
            at_origin   <= 1'b1;
        end else begin
            frame_start <= frame_boundary;
            if (en) begin
                col_addr  <= h_cnt;
                row_addr  <= v_cnt;
                ready     <= (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
                hsync     <= ((h_cnt >= HS_START) && (h_cnt < HS_STOP)) ? HSYNC_POL : ~HSYNC_POL;
                vsync     <= ((v_cnt >= VS_START) && (v_cnt < VS_STOP)) ? VSYNC_POL : ~VSYNC_POL;
                at_origin <= v_wrap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MANUAL;
            mode      <= '0;
            frame_cnt <= '0;
            pend      <= 1'b0;
            pend_mode <= '0;
            pend_auto <= 1'b0;
        end else begin
            state     <= state_nxt;
            mode      <= mode_nxt;
            frame_cnt <= frame_cnt_nxt;
            pend      <= pend_nxt;
            pend_mode <= pend_mode_nxt;
            pend_auto <= pend_auto_nxt;
        end
    end

    // A request accepted on a boundary cycle sees pend=0 there, so it waits for the next frame.
    always_comb begin
        state_nxt     = state;
        mode_nxt      = mode;
        frame_cnt_nxt = frame_cnt;
        pend_nxt      = pend;
        pend_mode_nxt = pend_mode;
        pend_auto_nxt = pend_auto;
        if (cfg_valid && !pend) begin
            pend_nxt      = 1'b1;
            pend_mode_nxt = ({1'b0, cfg_mode} >= MODE_LIMIT) ? mode_t'(0) : cfg_mode;
            pend_auto_nxt = cfg_auto;
        end
        if (frame_boundary) begin
            if (pend) begin
                mode_nxt      = pend_mode;
                state_nxt     = pend_auto ? AUTO : MANUAL;
                frame_cnt_nxt = '0;
                pend_nxt      = 1'b0;
            end else if ((state == AUTO) && (frame_cnt == FRAME_LAST)) begin
                mode_nxt      = (mode == MODE_LAST) ? mode_t'(0) : mode + mode_t'(1);
                frame_cnt_nxt = '0;
            end else if (frame_cnt != FRAME_LAST) begin
                frame_cnt_nxt = frame_cnt + FCNT_W'(1);
            end
        end
    end

    always_comb begin
        cfg_ready = ~pend;
    end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl on a shrunken 15x10 raster, 3 frames per mode, 5 modes.
module tb_video_timing_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic [2:0]  cfg_mode;
    logic        cfg_auto;
    logic        cfg_ready;
    logic [10:0] col_addr;
    logic [10:0] row_addr;
    logic        ready;
    logic        hsync;
    logic        vsync;
    logic [2:0]  mode;
    logic        frame_start;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    video_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .FRAMES_PER_MODE(3), .NUM_MODES(5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_mode    (cfg_mode),
        .cfg_auto    (cfg_auto),
        .cfg_ready   (cfg_ready),
        .col_addr    (col_addr),
        .row_addr    (row_addr),
        .ready       (ready),
        .hsync       (hsync),
        .vsync       (vsync),
        .mode        (mode),
        .frame_start (frame_start)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic e);
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic waitFrameStart(input string tag, input logic [2:0] exp_mode);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            applyStimulus(1'b1);
            seen = frame_start;
        end
        checkOutput({tag, "_seen"}, seen, 1);
        checkOutput({tag, "_mode"}, mode, exp_mode);
    endtask

    task automatic stepTo(input string tag, input int c, input int r);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            applyStimulus(1'b1);
            hit = (col_addr == 11'(c)) && (row_addr == 11'(r));
        end
        checkOutput({tag, "_reached"}, hit, 1);
    endtask

    task automatic sendRequest(input logic [2:0] m, input logic a);
        cfg_valid = 1'b1;
        cfg_mode  = m;
        cfg_auto  = a;
        applyStimulus(1'b1);
        cfg_valid = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_col"},   col_addr, 0);
        checkOutput({tag, "_row"},   row_addr, 0);
        checkOutput({tag, "_ready"}, ready, 0);
        checkOutput({tag, "_fs"},    frame_start, 0);
        checkOutput({tag, "_hsync"}, hsync, 1);
        checkOutput({tag, "_vsync"}, vsync, 1);
        checkOutput({tag, "_mode"},  mode, 0);
        checkOutput({tag, "_cfgrdy"}, cfg_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ec, er;
        int first_fs, second_fs;
        logic [10:0] prev_col, prev_row;
        logic e;

        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_mode = 3'd0; cfg_auto = 1'b0;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkResetState("reset");

        // First enabled cycle presents the origin and is a frame boundary.
        rst = 1'b0;
        applyStimulus(1'b1);
        checkOutput("first_col",   col_addr, 0);
        checkOutput("first_row",   row_addr, 0);
        checkOutput("first_ready", ready, 1);
        checkOutput("first_fs",    frame_start, 1);

        // One full frame of 150 en cycles; active 0..7/0..5, hsync 10..12, vsync 7..8.
        ec = 0; er = 0;
        for (int n = 1; n <= 150; n++) begin
            ec = (ec == 14) ? 0 : ec + 1;
            if (ec == 0) er = (er == 9) ? 0 : er + 1;
            applyStimulus(1'b1);
            checkOutput("scan_col",   col_addr, ec);
            checkOutput("scan_row",   row_addr, er);
            checkOutput("scan_ready", ready, (ec < 8 && er < 6) ? 1 : 0);
            checkOutput("scan_hsync", hsync, (ec >= 10 && ec < 13) ? 0 : 1);
            checkOutput("scan_vsync", vsync, (er >= 7 && er < 9) ? 0 : 1);
            checkOutput("scan_fs",    frame_start, (ec == 0 && er == 0) ? 1 : 0);
        end

        // en asserted one cycle in three: frame period becomes 450 clk.
        first_fs = -1; second_fs = -1;
        prev_col = col_addr; prev_row = row_addr;
        for (int i = 0; i < 2000 && second_fs < 0; i++) begin
            e = (i % 3 == 0);
            applyStimulus(e);
            if (!e) begin
                checkOutput("hold_col", col_addr, prev_col);
                checkOutput("hold_row", row_addr, prev_row);
                checkOutput("fs_width", frame_start, 0);
            end
            if (frame_start) begin
                if (first_fs < 0) first_fs = i;
                else second_fs = i;
            end
            prev_col = col_addr; prev_row = row_addr;
        end
        checkOutput("gated_period", second_fs - first_fs, 450);

        // Auto request mid-frame, then a second request that must be refused.
        stepTo("auto_mid", 5, 3);
        sendRequest(3'd3, 1'b1);
        checkOutput("auto_pend_rdy",  cfg_ready, 0);
        checkOutput("auto_pend_mode", mode, 0);
        cfg_valid = 1'b1; cfg_mode = 3'd1; cfg_auto = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1);
            checkOutput("busy_rdy",  cfg_ready, 0);
            checkOutput("busy_mode", mode, 0);
        end
        cfg_valid = 1'b0;
        waitFrameStart("auto_b0", 3'd3);
        checkOutput("auto_b0_rdy", cfg_ready, 1);
        waitFrameStart("auto_b1", 3'd3);
        waitFrameStart("auto_b2", 3'd3);
        waitFrameStart("auto_b3", 3'd4);
        waitFrameStart("auto_b4", 3'd4);
        waitFrameStart("auto_b5", 3'd4);
        waitFrameStart("auto_b6", 3'd0);

        // Manual mode holds across frames; out-of-range mode lands on 0.
        stepTo("man_mid", 5, 3);
        sendRequest(3'd2, 1'b0);
        waitFrameStart("man_b0", 3'd2);
        waitFrameStart("man_b1", 3'd2);
        waitFrameStart("man_b2", 3'd2);
        waitFrameStart("man_b3", 3'd2);
        stepTo("clamp_mid", 5, 3);
        sendRequest(3'd7, 1'b0);
        waitFrameStart("clamp", 3'd0);

        // Request accepted on the boundary cycle applies one frame later.
        stepTo("pre_bnd", 14, 9);
        sendRequest(3'd4, 1'b0);
        checkOutput("bnd_fs",   frame_start, 1);
        checkOutput("bnd_mode", mode, 0);
        checkOutput("bnd_rdy",  cfg_ready, 0);
        waitFrameStart("bnd_late", 3'd4);

        // Reset at row 2 in AUTO with a request pending.
        stepTo("rst_mid", 5, 3);
        sendRequest(3'd3, 1'b1);
        waitFrameStart("rst_auto", 3'd3);
        stepTo("rst_row2", 4, 2);
        sendRequest(3'd1, 1'b1);
        checkOutput("rst_pend_rdy", cfg_ready, 0);
        rst = 1'b1;
        applyStimulus(1'b1);
        checkResetState("midrst");
        rst = 1'b0;
        waitFrameStart("post_b0", 3'd0);
        waitFrameStart("post_b1", 3'd0);
        waitFrameStart("post_b2", 3'd0);
        waitFrameStart("post_b3", 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
